// File: rtl/axi_bcd_disp_writer.sv
`default_nettype none
// ============================================================================
//  Module   : axi_bcd_disp_writer
//  Purpose  : Feeds an AXI4-Lite 7-segment display controller. It accepts an
//             unsigned binary value on a valid/ready stream and converts it to
//             NDIGITS packed BCD nibbles with an iterative double-dabble at one
//             bit per cycle. It then writes the nibbles to the controller's
//             digit register as a write-only AXI4-Lite master. Controller
//             digit 0 is the rightmost (least significant) nibble.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready / in_value / in_dp   input value stream
//             awaddr awprot awvalid awready            AXI write address
//             wdata wstrb wvalid wready                AXI write data
//             bresp bvalid bready                      AXI write response
//             busy  - high whenever the block is not idle
//             ovf   - last accepted value did not fit in NDIGITS digits
//             err   - last write response was not OKAY
//  Option   : `define DP_WRITE_EN adds a second write of the captured in_dp
//             bits to ADDR_DP after the digit write.
//  Revision : 1.0  initial release
// ============================================================================
module axi_bcd_disp_writer #(
    parameter int NDIGITS    = 8,
    parameter int BIN_WIDTH  = 27,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SEG   = 0,
    parameter int ADDR_DP    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    in_value,
    input  logic [NDIGITS-1:0]      in_dp,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    busy,
    output logic                    ovf,
    output logic                    err
);

    localparam int C_BCD_W = 4 * NDIGITS;
    localparam int C_CNT_W = $clog2(BIN_WIDTH);

    // 10**NDIGITS evaluated at elaboration time in 64 bits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0]           C_LIMIT     = pow10(NDIGITS);
    localparam logic [C_CNT_W-1:0]    C_CNT_LAST  = C_CNT_W'(BIN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] C_WDATA_OVF = DATA_WIDTH'({NDIGITS{4'hE}});

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONV    = 3'd1,
        ST_WR      = 3'd2,
        ST_RESP    = 3'd3,
        ST_WR_DP   = 3'd4,
        ST_RESP_DP = 3'd5
    } state_t;

    state_t                  state_q,   state_d;
    logic [BIN_WIDTH-1:0]    shift_q,   shift_d;
    logic [C_BCD_W-1:0]      bcd_q,     bcd_d;
    logic [C_CNT_W-1:0]      cnt_q,     cnt_d;
    logic                    ovf_q,     ovf_d;
    logic                    err_q,     err_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    bready_q,  bready_d;
`ifdef DP_WRITE_EN
    logic [NDIGITS-1:0]      dp_q,      dp_d;
`else
    // The DP bits are not written in this build.
    logic                    w_unused_dp;
    assign w_unused_dp = ^in_dp;
`endif

    logic [C_BCD_W-1:0]      w_bcd_adj;
    logic [C_BCD_W-1:0]      w_bcd_next;
    logic                    w_aw_done;
    logic                    w_w_done;

    // Double-dabble step: correct every nibble >= 5 by +3, then shift the
    // next binary MSB in. Whatever leaves the top of the BCD register is lost.
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[C_BCD_W-2:0], shift_q[BIN_WIDTH-1]};
    end

    // A channel counts as done when its valid is already low or is being
    // accepted this cycle, so the two handshakes may land in any order.
    assign w_aw_done = !awvalid_q || awready;
    assign w_w_done  = !wvalid_q  || wready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
`ifdef DP_WRITE_EN
        dp_d      = dp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = in_value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (64'(in_value) >= C_LIMIT);
`ifdef DP_WRITE_EN
                    dp_d    = in_dp;
`endif
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d   = w_bcd_next;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + C_CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    wdata_d   = ovf_q ? C_WDATA_OVF : DATA_WIDTH'(w_bcd_next);
                    awaddr_d  = ADDR_WIDTH'(ADDR_SEG);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_WR;
                end
            end
            ST_WR, ST_WR_DP: begin
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (w_aw_done && w_w_done) begin
                    bready_d = 1'b1;
                    state_d  = (state_q == ST_WR) ? ST_RESP : ST_RESP_DP;
                end
            end
            ST_RESP: begin
                if (bvalid) begin
                    err_d    = (bresp != 2'b00);
                    bready_d = 1'b0;
`ifdef DP_WRITE_EN
                    awaddr_d  = ADDR_WIDTH'(ADDR_DP);
                    wdata_d   = DATA_WIDTH'(dp_q);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_WR_DP;
`else
                    state_d  = ST_IDLE;
`endif
                end
            end
            ST_RESP_DP: begin
                if (bvalid) begin
                    err_d    = (bresp != 2'b00);
                    bready_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`ifdef DP_WRITE_EN
            dp_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
`ifdef DP_WRITE_EN
            dp_q      <= dp_d;
`endif
        end
    end

    // in_ready is gated by rst so it drops immediately while reset is held.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign busy     = (state_q != ST_IDLE);
    assign ovf      = ovf_q;
    assign err      = err_q;
    assign awaddr   = awaddr_q;
    assign awprot   = 3'b000;
    assign awvalid  = awvalid_q;
    assign wdata    = wdata_q;
    assign wstrb    = '1;
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_bcd_disp_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_bcd_disp_writer
//  Purpose  : Self-checking bench for axi_bcd_disp_writer (default build,
//             NDIGITS=8, BIN_WIDTH=27). Values are randomized around the
//             interesting ranges, the AXI slave side uses random delays and
//             responses, and expected digits come from a decimal model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_bcd_disp_writer;

    localparam int NDIG = 8;
    localparam int BW   = 27;
    localparam int AW   = 3;
    localparam int DW   = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     in_value;
    logic [NDIG-1:0]   in_dp;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic              busy;
    logic              ovf;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    axi_bcd_disp_writer #(
        .NDIGITS    (NDIG),
        .BIN_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ADDR_SEG   (0),
        .ADDR_DP    (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_dp    (in_dp),
        .awaddr   (awaddr),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .busy     (busy),
        .ovf      (ovf),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Decimal reference: digits of v, least significant in nibble 0, or all-E
    // when v needs more than NDIG digits.
    function automatic logic [31:0] ref_digits(input longint unsigned v);
        logic [31:0]       r;
        longint unsigned   t;
        longint unsigned   lim;
        lim = 1;
        for (int i = 0; i < NDIG; i++) lim = lim * 10;
        if (v >= lim) return {NDIG{4'hE}};
        r = '0;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic do_txn(input logic [BW-1:0] v, input logic [1:0] br,
                          input int da, input int dw, input int db);
        logic [31:0] exp_w;
        logic        exp_ovf;
        int          n;
        int          k;
        int          j;
        bit          aw_done;
        bit          w_done;
        exp_w   = ref_digits(longint'(v));
        exp_ovf = (longint'(v) >= 64'd100000000);

        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_value = v;
        @(negedge clk);
        // Keep valid high with a different value: it must be ignored while busy.
        in_value = ~v;
        chk_eq("busy_conv", busy, 1);
        chk_eq("in_ready_conv", in_ready, 0);
        n = 1;
        while (!awvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk_eq("aw_latency", n, BW + 1);

        aw_done = 0;
        w_done  = 0;
        k       = 0;
        while (!(aw_done && w_done) && k < 50) begin
            chk_eq("awvalid_wr", awvalid, !aw_done);
            chk_eq("wvalid_wr", wvalid, !w_done);
            if (!aw_done) chk_eq("awaddr", awaddr, 0);
            if (!w_done)  chk_eq("wdata", wdata, exp_w);
            awready = (k >= da);
            wready  = (k >= dw);
            @(negedge clk);
            if (awready) aw_done = 1;
            if (wready)  w_done  = 1;
            k++;
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk_eq("wr_done_bound", (aw_done && w_done), 1);
        chk_eq("awvalid_after", awvalid, 0);
        chk_eq("wvalid_after", wvalid, 0);

        j = 0;
        while (j < 50) begin
            chk_eq("bready_resp", bready, 1);
            if (j >= db) begin
                bvalid = 1'b1;
                bresp  = br;
                @(negedge clk);
                bvalid = 1'b0;
                bresp  = 2'b00;
                break;
            end
            @(negedge clk);
            j++;
        end
        chk_eq("bready_after", bready, 0);
        chk_eq("busy_after", busy, 0);
        chk_eq("in_ready_after", in_ready, 1);
        chk_eq("ovf", ovf, exp_ovf);
        chk_eq("err", err, (br != 2'b00));
    endtask

    initial begin
        logic [BW-1:0] v;
        logic [1:0]    br;
        int            sel;
        int            n;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        in_dp    = '0;
        awready  = 1'b0;
        wready   = 1'b0;
        bresp    = 2'b00;
        bvalid   = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_in_ready", in_ready, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_awvalid", awvalid, 0);
        chk_eq("rst_wvalid", wvalid, 0);
        chk_eq("rst_bready", bready, 0);
        chk_eq("rst_awaddr", awaddr, 0);
        chk_eq("rst_wdata", wdata, 0);
        chk_eq("rst_ovf", ovf, 0);
        chk_eq("rst_err", err, 0);
        chk_eq("awprot", awprot, 0);
        chk_eq("wstrb", wstrb, 4'hF);
        rst = 1'b0;
        @(negedge clk);

        do_txn(27'd12345678,  2'b00, 0, 0, 0);
        do_txn(27'd100000000, 2'b00, 0, 0, 0);
        do_txn(27'd99999999,  2'b00, 0, 0, 0);
        do_txn(27'd0,         2'b00, 1, 1, 2);
        do_txn(27'd12345678,  2'b10, 0, 3, 1);
        do_txn(27'd87654321,  2'b00, 2, 0, 0);
        do_txn(27'h7FFFFFF,   2'b11, 4, 4, 3);

        // Reset while the digit write is outstanding; ovf and err are set here.
        in_valid = 1'b1;
        in_value = 27'd100000000;
        n = 0;
        @(negedge clk);
        while (!awvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk_eq("pre_rst_awvalid", awvalid, 1);
        rst = 1'b1;
        #1;
        chk_eq("mid_rst_awvalid", awvalid, 0);
        chk_eq("mid_rst_wvalid", wvalid, 0);
        chk_eq("mid_rst_bready", bready, 0);
        chk_eq("mid_rst_in_ready", in_ready, 0);
        chk_eq("mid_rst_ovf", ovf, 0);
        chk_eq("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_eq("post_rst_in_ready", in_ready, 1);
        chk_eq("post_rst_busy", busy, 0);
        @(negedge clk);
        chk_eq("post_rst_idle_awvalid", awvalid, 0);

        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       v = BW'($urandom);
                1:       v = BW'($urandom_range(0, 99999999));
                2:       v = BW'($urandom_range(99999990, 100000010));
                default: v = BW'($urandom_range(0, 999));
            endcase
            br = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_txn(v, br, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
